// File: rtl/exe_stage_pkg.sv
// -----------------------------------------------------------------------------
// exe_stage_pkg
// Shared constants and enumerations for the execute stage and its iterative
// multiplier.
//   WORD_LEN    : data path width
//   INST_LEN    : instruction / PC width
//   EXE_CMD_LEN : width of the operation code
//   exe_cmd_e   : operation codes (10..15 are unused and act as NOP)
//   mul_state_e : multiplier sequencer states
// -----------------------------------------------------------------------------
package exe_stage_pkg;

    localparam int WORD_LEN    = 16;
    localparam int INST_LEN    = 16;
    localparam int EXE_CMD_LEN = 4;

    typedef enum logic [EXE_CMD_LEN-1:0] {
        CMD_NOP  = 4'd0,
        CMD_ADD  = 4'd1,
        CMD_SUB  = 4'd2,
        CMD_AND  = 4'd3,
        CMD_OR   = 4'd4,
        CMD_XOR  = 4'd5,
        CMD_SHL  = 4'd6,
        CMD_SHR  = 4'd7,
        CMD_MOVB = 4'd8,
        CMD_MUL  = 4'd9
    } exe_cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/exe_mul.sv
// -----------------------------------------------------------------------------
// exe_mul
// Iterative 16x16 shift-add multiplier keeping the low WORD_LEN bits of the
// unsigned product. One partial-product step per clock while BUSY.
//
// Handshake: start is sampled only in IDLE; on that edge the operands,
// destination and write enable are latched and the unit enters BUSY. After
// 16 steps it sits one cycle in DONE, where product/dest_q/wen_q are valid,
// then returns to IDLE. There is no backpressure: the consumer must take the
// result during DONE.
//
// Ports:
//   clk, nReset      clock, asynchronous active-low reset
//   start            request a multiply (meaningful in IDLE only)
//   a, b             operands
//   dest, wen        destination register / write enable to carry along
//   state            current sequencer state (also used for observation)
//   product          low 16 bits of a*b, valid in DONE
//   dest_q, wen_q    latched destination / write enable
// -----------------------------------------------------------------------------
module exe_mul
    import exe_stage_pkg::*;
(
    input  logic                clk,
    input  logic                nReset,
    input  logic                start,
    input  logic [WORD_LEN-1:0] a,
    input  logic [WORD_LEN-1:0] b,
    input  logic [3:0]          dest,
    input  logic                wen,
    output mul_state_e          state,
    output logic [WORD_LEN-1:0] product,
    output logic [3:0]          dest_q,
    output logic                wen_q
);

    mul_state_e          state_next;
    logic [3:0]          count;
    logic [WORD_LEN-1:0] mcand;
    logic [WORD_LEN-1:0] mplier;
    logic [WORD_LEN-1:0] acc;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (count == 4'd15) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Multiplicand moves left and multiplier moves right each step, so bit 0
    // of mplier always selects whether the current shifted multiplicand is
    // added. Bits shifted out of mcand are beyond the kept 16-bit result.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            count  <= 4'd0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            dest_q <= 4'd0;
            wen_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count  <= 4'd0;
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        dest_q <= dest;
                        wen_q  <= wen;
                    end
                end
                BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 4'd1;  // wraps 15 -> 0 on the last step
                end
                default: begin
                end
            endcase
        end
    end

    assign product = acc;

endmodule

// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
// Execute stage: single-cycle ALU, conditional branch resolution and an
// optional iterative multiplier that stalls the front of the pipeline.
//
// Build option: define EXE_MUL_EN to include the multiplier. Without it,
// opcode 9 behaves as NOP and Stall is tied low.
//
// Ports:
//   clk, nReset    clock, asynchronous active-low reset
//   ImSel          operand B select: 1 = IMMG, 0 = RD2
//   xSel           operand A select: 1 = PC,   0 = RD1
//   Reg_W_En       instruction writes a register
//   BranchTK       instruction is a conditional branch (taken if RD1 == RD2)
//   EXE_CMD        operation code (exe_cmd_e)
//   PC             instruction address
//   Instruction    raw instruction, [11:8] = destination register
//   IMMG           sign-extended immediate
//   RD1, RD2       register operands
//   Stall          hold IF/ID and ID2EXE (combinational)
//   WB_En, WB_Dest, WB_Data   registered write-back
//   Br_Taken, Br_Addr         registered one-cycle branch redirect
//
// Pipeline handshake: when Stall is high the upstream registers hold, the
// instruction presented here is ignored except for the multiply capture, and
// this stage produces neither write-back nor redirect. When Stall is low the
// presented instruction is consumed at the next rising edge.
// -----------------------------------------------------------------------------
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   ImSel,
    input  logic                   xSel,
    input  logic                   Reg_W_En,
    input  logic                   BranchTK,
    input  logic [EXE_CMD_LEN-1:0] EXE_CMD,
    input  logic [INST_LEN-1:0]    PC,
    input  logic [INST_LEN-1:0]    Instruction,
    input  logic [WORD_LEN-1:0]    IMMG,
    input  logic [WORD_LEN-1:0]    RD1,
    input  logic [WORD_LEN-1:0]    RD2,
    output logic                   Stall,
    output logic                   WB_En,
    output logic [3:0]             WB_Dest,
    output logic [WORD_LEN-1:0]    WB_Data,
    output logic                   Br_Taken,
    output logic [INST_LEN-1:0]    Br_Addr
);

    logic [WORD_LEN-1:0] op_a;
    logic [WORD_LEN-1:0] op_b;
    logic [WORD_LEN-1:0] alu_result;
    logic                alu_valid;

    logic                stall_int;
    logic                mul_done;
    logic [WORD_LEN-1:0] mul_product;
    logic [3:0]          mul_dest;
    logic                mul_wen;

    // Only the destination field of the raw instruction matters here.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{Instruction[15:12], Instruction[7:0]};

    always_comb begin
        op_a       = xSel  ? PC   : RD1;
        op_b       = ImSel ? IMMG : RD2;
        alu_result = '0;
        alu_valid  = 1'b1;
        case (EXE_CMD)
            CMD_ADD:  alu_result = op_a + op_b;
            CMD_SUB:  alu_result = op_a - op_b;
            CMD_AND:  alu_result = op_a & op_b;
            CMD_OR:   alu_result = op_a | op_b;
            CMD_XOR:  alu_result = op_a ^ op_b;
            CMD_SHL:  alu_result = op_a << op_b[3:0];
            CMD_SHR:  alu_result = op_a >> op_b[3:0];
            CMD_MOVB: alu_result = op_b;
            // NOP, MUL (handled by the sequencer) and unused codes never
            // write back through the single-cycle path.
            default:  alu_valid  = 1'b0;
        endcase
    end

`ifdef EXE_MUL_EN
    mul_state_e mul_state;
    logic       is_mul;

    assign is_mul = (EXE_CMD == CMD_MUL);

    exe_mul u_mul (
        .clk     (clk),
        .nReset  (nReset),
        .start   (is_mul),
        .a       (op_a),
        .b       (op_b),
        .dest    (Instruction[11:8]),
        .wen     (Reg_W_En),
        .state   (mul_state),
        .product (mul_product),
        .dest_q  (mul_dest),
        .wen_q   (mul_wen)
    );

    // The capture cycle already stalls so the MUL stays presented until the
    // sequencer owns it; DONE releases the pipeline one cycle early so the
    // next instruction arrives exactly as the product is written back.
    assign stall_int = ((mul_state == IDLE) && is_mul) || (mul_state == BUSY);
    assign mul_done  = (mul_state == DONE);
`else
    assign stall_int   = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
    assign mul_dest    = 4'd0;
    assign mul_wen     = 1'b0;
`endif

    assign Stall = stall_int;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            WB_En    <= 1'b0;
            WB_Dest  <= 4'd0;
            WB_Data  <= '0;
            Br_Taken <= 1'b0;
            Br_Addr  <= '0;
        end else if (stall_int) begin
            WB_En    <= 1'b0;
            Br_Taken <= 1'b0;
        end else if (mul_done) begin
            // The instruction still presented in DONE is the held MUL itself,
            // so it must not be executed a second time.
            WB_En    <= mul_wen;
            WB_Dest  <= mul_dest;
            WB_Data  <= mul_product;
            Br_Taken <= 1'b0;
        end else begin
            WB_En    <= Reg_W_En && alu_valid;
            WB_Dest  <= Instruction[11:8];
            WB_Data  <= alu_result;
            Br_Taken <= BranchTK && (RD1 == RD2);
            Br_Addr  <= PC + IMMG;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage
// Directed bench for exe_stage. A reference model computes the expected
// outputs from the instruction stream; a negedge process compares the DUT
// against it every cycle, and the directed sequence adds literal checks.
// Define EXE_MUL_EN to exercise the multiplier build.
// -----------------------------------------------------------------------------
module tb_exe_stage;
    import exe_stage_pkg::*;

`ifdef EXE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        nReset = 1'b1;
    always #5 clk = ~clk;

    logic        ImSel = 1'b0;
    logic        xSel = 1'b0;
    logic        Reg_W_En = 1'b0;
    logic        BranchTK = 1'b0;
    logic [3:0]  EXE_CMD = 4'd0;
    logic [15:0] PC = 16'd0;
    logic [15:0] Instruction = 16'd0;
    logic [15:0] IMMG = 16'd0;
    logic [15:0] RD1 = 16'd0;
    logic [15:0] RD2 = 16'd0;
    logic        Stall;
    logic        WB_En;
    logic [3:0]  WB_Dest;
    logic [15:0] WB_Data;
    logic        Br_Taken;
    logic [15:0] Br_Addr;

    exe_stage dut (
        .clk         (clk),
        .nReset      (nReset),
        .ImSel       (ImSel),
        .xSel        (xSel),
        .Reg_W_En    (Reg_W_En),
        .BranchTK    (BranchTK),
        .EXE_CMD     (EXE_CMD),
        .PC          (PC),
        .Instruction (Instruction),
        .IMMG        (IMMG),
        .RD1         (RD1),
        .RD2         (RD2),
        .Stall       (Stall),
        .WB_En       (WB_En),
        .WB_Dest     (WB_Dest),
        .WB_Data     (WB_Data),
        .Br_Taken    (Br_Taken),
        .Br_Addr     (Br_Addr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mul_phase: 0 = no multiply in flight, k = k-th cycle after capture.
    // Cycles 1..16 stall, cycle 17 does not, its closing edge writes back.
    int          mul_phase = 0;
    logic        m_wb_en = 1'b0;
    logic [3:0]  m_dest = 4'd0;
    logic [15:0] m_data = 16'd0;
    logic        m_br = 1'b0;
    logic [15:0] m_br_addr = 16'd0;
    logic [15:0] p_prod = 16'd0;
    logic [3:0]  p_dest = 4'd0;
    logic        p_wen = 1'b0;

    function automatic logic model_stall();
        return MUL_EN && ((mul_phase == 0 && EXE_CMD == 4'd9) ||
                          (mul_phase >= 1 && mul_phase <= 16));
    endfunction

    function automatic logic [15:0] model_alu(input int cmd, input int a, input int b);
        int r;
        case (cmd)
            1: r = a + b;
            2: r = a - b + 65536;
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = a * (1 << (b % 16));
            7: r = a / (1 << (b % 16));
            8: r = b;
            default: r = 0;
        endcase
        return 16'(r % 65536);
    endfunction

    always @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            mul_phase <= 0;
            m_wb_en   <= 1'b0;
            m_dest    <= 4'd0;
            m_data    <= 16'd0;
            m_br      <= 1'b0;
            m_br_addr <= 16'd0;
        end else if (MUL_EN && mul_phase == 17) begin
            m_wb_en   <= p_wen;
            m_dest    <= p_dest;
            m_data    <= p_prod;
            m_br      <= 1'b0;
            mul_phase <= 0;
        end else if (model_stall()) begin
            if (mul_phase == 0) begin
                longint a, b;
                a = xSel ? PC : RD1;
                b = ImSel ? IMMG : RD2;
                p_prod <= 16'((a * b) % 65536);
                p_dest <= Instruction[11:8];
                p_wen  <= Reg_W_En;
            end
            mul_phase <= mul_phase + 1;
            m_wb_en   <= 1'b0;
            m_br      <= 1'b0;
        end else begin
            m_wb_en   <= Reg_W_En && (EXE_CMD >= 4'd1) && (EXE_CMD <= 4'd8);
            m_dest    <= Instruction[11:8];
            m_data    <= model_alu(int'(EXE_CMD), int'(xSel ? PC : RD1), int'(ImSel ? IMMG : RD2));
            m_br      <= BranchTK && (RD1 == RD2);
            m_br_addr <= 16'((int'(PC) + int'(IMMG)) % 65536);
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        check("stall", Stall, model_stall());
        check("wb_en", WB_En, m_wb_en);
        if (m_wb_en) begin
            check("wb_dest", WB_Dest, m_dest);
            check("wb_data", WB_Data, m_data);
        end
        check("br_taken", Br_Taken, m_br);
        if (m_br) check("br_addr", Br_Addr, m_br_addr);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [15:0] rd1, input logic [15:0] rd2,
                         input logic [15:0] imm, input logic [15:0] pc, input logic imsel,
                         input logic xsel, input logic wen, input logic brtk, input logic [3:0] dest);
        EXE_CMD     = cmd;
        RD1         = rd1;
        RD2         = rd2;
        IMMG        = imm;
        PC          = pc;
        ImSel       = imsel;
        xSel        = xsel;
        Reg_W_En    = wen;
        BranchTK    = brtk;
        Instruction = {4'hA, dest, 8'h5C};
        #1;
    endtask

    task automatic nop();
        drive(4'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    // Counts consecutive Stall-high cycles starting with the current one.
    task automatic count_stall(output int n);
        n = 0;
        while (Stall === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        #1 nReset = 1'b0;
        tick();
        tick();
        check("rst_stall", Stall, 1'b0);
        check("rst_wb_en", WB_En, 1'b0);
        check("rst_wb_dest", WB_Dest, 4'd0);
        check("rst_wb_data", WB_Data, 16'h0000);
        check("rst_br_taken", Br_Taken, 1'b0);
        check("rst_br_addr", Br_Addr, 16'h0000);
        nReset = 1'b1;
        tick();

        // ADD overflow wraps into the sign bit
        drive(4'd1, 16'h7FFF, 16'h0, 16'h0001, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
        tick();
        check("add_en", WB_En, 1'b1);
        check("add_dest", WB_Dest, 4'd3);
        check("add_data", WB_Data, 16'h8000);

        drive(4'd2, 16'h0000, 16'h0001, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
        tick();
        check("sub_data", WB_Data, 16'hFFFF);

        drive(4'd12, 16'h1111, 16'h2222, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
        tick();
        check("cmd12_en", WB_En, 1'b0);

        drive(4'd3, 16'hF0F0, 16'h3C3C, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6);
        tick();
        check("and_data", WB_Data, 16'h3030);
        drive(4'd4, 16'hF0F0, 16'h3C3C, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6);
        tick();
        check("or_data", WB_Data, 16'hFCFC);
        drive(4'd5, 16'hF0F0, 16'h3C3C, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6);
        tick();
        check("xor_data", WB_Data, 16'hCCCC);
        drive(4'd6, 16'h0001, 16'h0013, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7);
        tick();
        check("shl_data", WB_Data, 16'h0008);
        drive(4'd7, 16'h8000, 16'h0, 16'h000F, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8);
        tick();
        check("shr_data", WB_Data, 16'h0001);
        drive(4'd8, 16'h1234, 16'h0, 16'hABCD, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9);
        tick();
        check("movb_data", WB_Data, 16'hABCD);
        drive(4'd1, 16'h5555, 16'h0020, 16'h0, 16'h0100, 1'b0, 1'b1, 1'b1, 1'b0, 4'd10);
        tick();
        check("pc_add_data", WB_Data, 16'h0120);
        drive(4'd1, 16'h0001, 16'h0001, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd11);
        tick();
        check("add_nowen_en", WB_En, 1'b0);

        // Branch taken with negative offset, then a one-cycle pulse check
        drive(4'd0, 16'h0042, 16'h0042, 16'hFFFC, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        tick();
        check("br_taken", Br_Taken, 1'b1);
        check("br_addr", Br_Addr, 16'h000C);
        nop();
        tick();
        check("br_pulse_end", Br_Taken, 1'b0);
        drive(4'd0, 16'h0042, 16'h0043, 16'hFFFC, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        tick();
        check("br_not_taken", Br_Taken, 1'b0);
        nop();
        tick();

`ifdef EXE_MUL_EN
        // MUL 0x0123 * 0x0010
        drive(4'd9, 16'h0123, 16'h0010, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
        count_stall(n);
        check("mul1_stall_len", n, 17);
        check("mul1_done_wb_en", WB_En, 1'b0);
        nop();
        tick();
        check("mul1_en", WB_En, 1'b1);
        check("mul1_dest", WB_Dest, 4'd5);
        check("mul1_data", WB_Data, 16'h1230);

        // 0xFFFF * 0xFFFF followed immediately by 3 * 5
        drive(4'd9, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7);
        count_stall(n);
        check("mul2_stall_len", n, 17);
        drive(4'd9, 16'h0003, 16'h0005, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
        tick();
        check("mul2_data", WB_Data, 16'h0001);
        check("mul2_dest", WB_Dest, 4'd7);
        check("mul3_recapture", Stall, 1'b1);
        count_stall(n);
        check("mul3_stall_len", n, 17);
        nop();
        tick();
        check("mul3_data", WB_Data, 16'h000F);

        // MUL without register write
        drive(4'd9, 16'h0002, 16'h0003, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        count_stall(n);
        check("mul4_stall_len", n, 17);
        nop();
        tick();
        check("mul4_no_wb", WB_En, 1'b0);

        // Reset while BUSY with count 7
        drive(4'd9, 16'h0007, 16'h0009, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
        for (int i = 0; i < 8; i++) tick();
        check("mid_busy_stall", Stall, 1'b1);
        nReset = 1'b0;
        nop();
        check("midrst_stall", Stall, 1'b0);
        check("midrst_wb_en", WB_En, 1'b0);
        check("midrst_wb_data", WB_Data, 16'h0000);
        check("midrst_br_addr", Br_Addr, 16'h0000);
        tick();
        nReset = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (WB_En !== 1'b0 || Stall !== 1'b0) n++;
        end
        check("midrst_no_wb", n, 0);
`else
        // Without the multiplier, opcode 9 is a NOP
        drive(4'd9, 16'h0123, 16'h0010, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
        check("nomul_stall", Stall, 1'b0);
        tick();
        check("nomul_stall_after", Stall, 1'b0);
        check("nomul_wb_en", WB_En, 1'b0);
        nop();
        tick();
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
